// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default frame constants
// used by the RX and TX sides and their assertions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int UART_OVERSAMPLE_DEF = 16;
    localparam int UART_DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop deserializer with a valid/ready holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS_DEF,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_rx: illegal parameter combination");
    end

    logic rxd_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 prev_q, prev_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            prev_q       <= 1'b1;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            prev_q       <= prev_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        prev_d       = prev_q;
        ferr_d       = ferr_q;
        perr_d       = perr_q;
        done_d       = 1'b0;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        if (sample_tick) begin
            prev_d = rxd_s;
            unique case (state_q)
                IDLE: begin
                    // Edge-triggered so a line held low cannot restart a frame.
                    if (!rxd_s && prev_q) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
                        perr_d  = 1'b0;
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = AFTER_DATA;
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        perr_d  = (^{shift_q, rxd_s}) != 1'(PARITY_ODD);
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!rxd_s) ferr_d = 1'b1;
                        // Return to IDLE at mid stop bit so the next start edge is never missed.
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (valid_q && rx_ready) valid_d = 1'b0;

        if (done_q) begin
            if (ferr_q || perr_q) begin
                frame_err_d  = ferr_q;
                parity_err_d = perr_q;
            end else if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (8 data bits, 1 stop, OVERSAMPLE=16): frame table plus
// hand sequences for false start, overrun, same-cycle accept, reset abort and parity.
module tb_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int n_xfer = 0, n_vcyc = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_both = 0;
    logic [7:0] last_data = 8'h00;

    // Event monitor samples just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rx_valid && rx_ready) begin
            n_xfer++;
            last_data = rx_data;
        end
        if (rx_valid)              n_vcyc++;
        if (frame_err)             n_ferr++;
        if (parity_err)            n_perr++;
        if (overrun)               n_ovr++;
        if (frame_err && overrun)  n_both++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_xfer = 0; n_vcyc = 0; n_ferr = 0; n_perr = 0; n_ovr = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) sample_tick = 1'b1;
            @(negedge clk) sample_tick = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(par);
        send_bit(stop);
        rxd = 1'b1;
        ticks(4);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par;
        int         exp_xfer;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data",  rx_data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_pulses", {frame_err, parity_err, overrun}, 0);
        rst_n = 1'b1;
        ticks(4);

        // Table: single frames with rx_ready held high
        for (int v = 0; v < 6; v++) begin
            rx_ready = 1'b1;
            clr_counts();
            send_frame(tbl[v].data, tbl[v].stop, tbl[v].par);
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_xfer", v), n_xfer, tbl[v].exp_xfer);
            chk($sformatf("v%0d_vcyc", v), n_vcyc, tbl[v].exp_xfer);
            if (tbl[v].exp_xfer != 0) chk($sformatf("v%0d_data", v), last_data, tbl[v].exp_data);
            chk($sformatf("v%0d_ferr", v), n_ferr, tbl[v].exp_ferr);
            chk($sformatf("v%0d_perr", v), n_perr, 0);
            chk($sformatf("v%0d_ovr", v), n_ovr, 0);
            chk($sformatf("v%0d_idle", v), {busy, rx_valid}, 0);
            ticks(4);
        end

        // False start: 4 low ticks then high
        clr_counts();
        rxd = 1'b0;
        ticks(3);
        chk("fs_busy_hi", busy, 1);
        ticks(1);
        rxd = 1'b1;
        ticks(OS);
        chk("fs_busy_lo", busy, 0);
        chk("fs_events", n_xfer + n_ferr + n_perr + n_ovr, 0);
        chk("fs_valid", rx_valid, 0);

        // Overrun: two frames with rx_ready low, then drain
        clr_counts();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_pulse", n_ovr, 1);
        chk("ovr_ferr", n_ferr, 0);
        rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain_xfer", n_xfer, 1);
        chk("drain_data", last_data, 8'h11);
        chk("drain_valid", rx_valid, 0);

        // New word completes in the very cycle the held word is accepted
        clr_counts();
        send_frame(8'h11, 1'b1, 1'b0);
        chk("sc_pre_valid", rx_valid, 1);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                int k;
                k = 0;
                while (!busy && k < 4000) begin @(negedge clk); k++; end
                while (busy && k < 4000) begin @(negedge clk); k++; end
                chk("sc_wait", k < 4000, 1);
                rx_ready = 1'b1;
                @(negedge clk) rx_ready = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("sc_valid", rx_valid, 1);
        chk("sc_data", rx_data, 8'h55);
        chk("sc_xfer", n_xfer, 1);
        chk("sc_xfer_data", last_data, 8'h11);
        chk("sc_ovr", n_ovr, 0);

        // Reset mid-DATA, then a clean frame
        clr_counts();
        rxd = 1'b0;
        ticks(3 * OS);
        chk("ra_busy_pre", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("ra_outs", {rx_valid, busy, frame_err, parity_err, overrun}, 0);
        chk("ra_data", rx_data, 0);
        rxd = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        ticks(4);
        rx_ready = 1'b1;
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("ra_xfer", n_xfer, 1);
        chk("ra_rxdata", last_data, 8'h7E);
        chk("ra_pulses", n_ferr + n_perr + n_ovr, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x01 sent with parity bit 0
        clr_counts();
        send_frame(8'h01, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_perr", n_perr, 1);
        chk("par_xfer", n_xfer, 0);
        chk("par_ferr", n_ferr, 0);
`endif

        chk("no_ferr_with_ovr", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
